// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-driven stimulus vector generator
// with a valid/ready output and bounded or free-running runs.
module lcg_stim_gen #(
  parameter int          OUT_W    = 139,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] MULT     = 32'h41C64E6D,
  parameter logic [31:0] INC      = 32'h3039,
  parameter logic [31:0] SEED_DEF = 32'hA1515607
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             stop,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [OUT_W-1:0] vec_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);
  localparam int NW = (OUT_W + 31) / 32;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    VALID,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]      lcg;
  logic [31:0]      lcg_nx;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] cnt_inc;
  logic             go;
  logic             acc;
  logic             last;
  logic             fill_en;

  assign lcg_nx  = lcg * MULT + INC;
  assign cnt_inc = vec_cnt + CNT_W'(1);
  assign go      = start && !stop;
  assign acc     = vec_valid && vec_ready && !stop;
  assign last    = (num_r != '0) && (cnt_inc == num_r);
  assign fill_en = (state == FILL) && !stop;

  assign vec_valid = (state == VALID);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go) state_nx = FILL;
      end
      FILL: begin
        if (stop) state_nx = IDLE;
        else if (k == K_LAST) state_nx = VALID;
      end
      VALID: begin
        if (stop) state_nx = IDLE;
        else if (acc) state_nx = last ? DONE : FILL;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lcg     <= SEED_DEF;
      k       <= '0;
      num_r   <= '0;
      vec_cnt <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          // a seed arriving with start feeds the very first step
          if (seed_load) lcg <= seed_in;
          if (go) begin
            k       <= '0;
            vec_cnt <= '0;
            num_r   <= num_vec;
          end
        end
        FILL: begin
          if (!stop) begin
            lcg <= lcg_nx;
            k   <= k + KW'(1);
          end
        end
        VALID: begin
          if (acc) begin
            vec_cnt <= cnt_inc;
            k       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar w = 0; w < NW; w++) begin : g_word
    localparam int LO = 32 * w;
    localparam int WB = (OUT_W - LO < 32) ? (OUT_W - LO) : 32;
    logic [WB-1:0] wd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd <= '0;
      else if (fill_en && (k == KW'(w))) wd <= lcg_nx[WB-1:0];
    end

    assign vec_data[LO +: WB] = wd;
  end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: self-checking bench for lcg_stim_gen
// (139-bit main instance plus 32- and 33-bit width corners).
module tb_lcg_stim_gen;
  logic         clk = 0;
  logic         rst_n;
  logic         seed_load;
  logic [31:0]  seed_in;
  logic         start;
  logic [31:0]  num_vec;
  logic         stop;
  logic         vec_ready;

  logic         v_big, busy_big, done_big;
  logic [138:0] d_big;
  logic [31:0]  cnt_big;
  logic         v32, busy32, done32;
  logic [31:0]  d32;
  logic [31:0]  cnt32;
  logic         v33, busy33, done33;
  logic [32:0]  d33;
  logic [31:0]  cnt33;

  int nchk = 0;
  int npass = 0;
  logic [31:0] ms;

  always #5 clk = ~clk;

  lcg_stim_gen u_big (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .num_vec(num_vec), .stop(stop), .vec_valid(v_big),
    .vec_ready(vec_ready), .vec_data(d_big), .busy(busy_big),
    .done(done_big), .vec_cnt(cnt_big)
  );

  lcg_stim_gen #(.OUT_W(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .num_vec(num_vec), .stop(stop), .vec_valid(v32),
    .vec_ready(vec_ready), .vec_data(d32), .busy(busy32),
    .done(done32), .vec_cnt(cnt32)
  );

  lcg_stim_gen #(.OUT_W(33)) u_w33 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .num_vec(num_vec), .stop(stop), .vec_valid(v33),
    .vec_ready(vec_ready), .vec_data(d33), .busy(busy33),
    .done(done33), .vec_cnt(cnt33)
  );

  typedef struct {
    logic        ld;
    logic [31:0] seed;
    int          nvec;
    int          pct;
    logic [31:0] w0;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] step(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic gen_vec(output logic [138:0] v);
    logic [159:0] t;
    t = '0;
    for (int w = 0; w < 5; w++) begin
      ms = step(ms);
      t[32*w +: 32] = ms;
    end
    v = t[138:0];
  endtask

  task automatic check(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (!v_big && c < budget) begin
      tick();
      c++;
    end
    check("valid_wait", v_big, 1);
  endtask

  task automatic run(input logic ld, input logic [31:0] sd,
                     input int nvec, input int target, input int pct,
                     input bit noise, output logic [31:0] w0);
    logic [138:0] ev;
    bit have, first;
    int acc, cyc;
    w0 = '0;
    if (ld) ms = sd;
    seed_load = ld;
    seed_in = sd;
    start = 1;
    num_vec = nvec;
    vec_ready = 0;
    tick();
    seed_load = 0;
    start = 0;
    num_vec = $urandom;
    acc = 0;
    cyc = 0;
    have = 0;
    first = 1;
    while (acc < target && cyc < 3000) begin
      if (v_big) begin
        if (!have) begin
          gen_vec(ev);
          have = 1;
          if (first) w0 = d_big[31:0];
          first = 0;
        end
        check("vec_data", d_big, ev);
      end
      check("no_early_done", done_big, 0);
      if (noise) begin
        seed_load = 1;
        start = 1;
        seed_in = $urandom;
      end
      vec_ready = ($urandom_range(99) < pct);
      if (v_big && vec_ready) begin
        acc++;
        have = 0;
      end
      tick();
      cyc++;
    end
    vec_ready = 0;
    seed_load = 0;
    start = 0;
    check("run_acc", acc, target);
    check("run_cnt", cnt_big, target);
    if (nvec != 0) begin
      check("done_pulse", done_big, 1);
      check("valid_in_done", v_big, 0);
      tick();
      check("done_low", done_big, 0);
      check("idle_after", busy_big, 0);
    end
  endtask

  initial begin
    logic [138:0] ev;
    logic [138:0] hold;
    logic [31:0] w0, s0, s1;
    rst_n = 0;
    seed_load = 0;
    seed_in = 0;
    start = 0;
    num_vec = 0;
    stop = 0;
    vec_ready = 0;
    ms = 32'hA1515607;
    tick();
    tick();
    check("rst_data", d_big, 0);
    check("rst_valid", v_big, 0);
    check("rst_busy", busy_big, 0);
    check("rst_done", done_big, 0);
    check("rst_cnt", cnt_big, 0);
    check("rst_d33", d33, 0);
    rst_n = 1;
    tick();
    check("idle_busy", busy_big, 0);

    // basic sequence and start-to-valid latency
    ms = 0;
    seed_load = 1;
    seed_in = 0;
    start = 1;
    num_vec = 1;
    tick();
    seed_load = 0;
    start = 0;
    for (int c = 1; c < 6; c++) begin
      check("lat_valid_low", v_big, 0);
      tick();
    end
    check("lat_valid_high", v_big, 1);
    check("basic_w0", d_big[31:0], 32'h00003039);
    check("basic_w1", d_big[63:32], 32'hD3DC167E);
    gen_vec(ev);
    check("basic_vec", d_big, ev);
    vec_ready = 1;
    tick();
    vec_ready = 0;
    check("basic_done", done_big, 1);
    check("basic_cnt", cnt_big, 1);
    tick();
    check("basic_done_low", done_big, 0);
    check("basic_idle", busy_big, 0);

    tbl[0] = '{1'b1, 32'h0, 1, 100, 32'h00003039};
    tbl[1] = '{1'b1, 32'h1, 2, 60, 32'h41C67EA6};
    for (int i = 2; i < 6; i++) begin
      tbl[i].ld = 1;
      tbl[i].seed = $urandom;
      tbl[i].nvec = $urandom_range(4, 1);
      tbl[i].pct = $urandom_range(100, 30);
      tbl[i].w0 = step(tbl[i].seed);
    end
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].ld, tbl[i].seed, tbl[i].nvec, tbl[i].nvec,
          tbl[i].pct, 0, w0);
      check("tbl_w0", w0, tbl[i].w0);
    end

    // backpressure: vector must hold while vec_ready is low
    start = 1;
    num_vec = 1;
    tick();
    start = 0;
    wait_valid(50);
    gen_vec(ev);
    hold = d_big;
    check("bp_first", d_big, ev);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", v_big, 1);
      check("bp_hold", d_big, hold);
      check("bp_cnt", cnt_big, 0);
    end
    vec_ready = 1;
    tick();
    vec_ready = 0;
    check("bp_cnt_one", cnt_big, 1);
    check("bp_done", done_big, 1);
    tick();

    // unbounded run, then stop together with vec_ready
    run(0, 0, 0, 100, 70, 0, w0);
    check("unb_no_done", done_big, 0);
    check("unb_busy", busy_big, 1);
    wait_valid(50);
    gen_vec(ev);
    check("unb_vec101", d_big, ev);
    stop = 1;
    vec_ready = 1;
    tick();
    stop = 0;
    vec_ready = 0;
    check("stop_idle", busy_big, 0);
    check("stop_valid", v_big, 0);
    check("stop_cnt", cnt_big, 100);
    check("stop_done", done_big, 0);
    check("stop_hold", d_big, ev);
    tick();
    check("stop_done2", done_big, 0);
    run(0, 0, 1, 1, 100, 0, w0);

    // seed_load and start while busy are ignored
    run(0, 0, 2, 2, 50, 1, w0);

    start = 1;
    stop = 1;
    tick();
    start = 0;
    stop = 0;
    check("start_stop_idle", busy_big, 0);
    tick();
    check("start_stop_idle2", busy_big, 0);

    // reset in the middle of a fill
    start = 1;
    num_vec = 1;
    tick();
    start = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    check("mrst_data", d_big, 0);
    check("mrst_valid", v_big, 0);
    check("mrst_busy", busy_big, 0);
    check("mrst_done", done_big, 0);
    check("mrst_cnt", cnt_big, 0);
    tick();
    rst_n = 1;
    tick();
    check("mrst_idle", busy_big, 0);
    ms = 32'hA1515607;
    run(0, 0, 1, 1, 100, 0, w0);
    check("mrst_w0", w0, step(32'hA1515607));

    // width corners; main instance is aborted mid-fill here
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    s0 = $urandom;
    s1 = step(s0);
    seed_load = 1;
    seed_in = s0;
    start = 1;
    num_vec = 1;
    tick();
    seed_load = 0;
    start = 0;
    check("w32_lat_low", v32, 0);
    tick();
    check("w32_lat_high", v32, 1);
    check("w32_data", d32, s1);
    check("w33_lat_low", v33, 0);
    tick();
    check("w33_lat_high", v33, 1);
    check("w33_lo", d33[31:0], s1);
    w0 = step(s1);
    check("w33_bit32", d33[32], w0[0]);
    hold = d_big;
    stop = 1;
    tick();
    stop = 0;
    check("fstop_idle", busy_big, 0);
    check("fstop_hold", d_big, hold);
    check("fstop_done", done_big, 0);
    check("fstop_cnt", cnt_big, 0);
    check("w32_stop_valid", v32, 0);
    check("w32_stop_hold", d32, s1);
    tick();
    check("fstop_done2", done_big, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/lcg_stim_gen.md
LCG_STIM_GEN -- requirements
Module: lcg_stim_gen

Interface
REQ-001 SHALL have parameter OUT_W, default 139: stimulus vector width, 1..1024.
REQ-002 SHALL have parameter CNT_W, default 32: vector counter width.
REQ-003 SHALL have parameter MULT, default 32'h41C64E6D: LCG multiplier.
REQ-004 SHALL have parameter INC, default 32'h3039: LCG increment.
REQ-005 SHALL have parameter SEED_DEF, default 32'hA1515607: reset seed.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port seed_load, input, 1: load seed_in into the LCG state.
REQ-009 SHALL have port seed_in, input, 32: new seed.
REQ-010 SHALL have port start, input, 1: begin a run.
REQ-011 SHALL have port num_vec, input, CNT_W: vectors per run; 0 means unbounded.
REQ-012 SHALL have port stop, input, 1: abort the run.
REQ-013 SHALL have port vec_valid, output, 1: vec_data holds a complete vector.
REQ-014 SHALL have port vec_ready, input, 1: consumer accepts the vector.
REQ-015 SHALL have port vec_data, output, OUT_W: stimulus vector.
REQ-016 SHALL have port busy, output, 1: FSM is not IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when a run completes.
REQ-018 SHALL have port vec_cnt, output, CNT_W: vectors accepted in the current run.

Function
REQ-019 SHALL implement FSM states IDLE, FILL, VALID and DONE.
REQ-020 SHALL define NW = ceil(OUT_W/32).
REQ-021 SHALL perform one LCG step per FILL cycle: state = (state*MULT + INC) mod 2^32.
REQ-022 SHALL write each new state into vec_data[32k+31:32k], k = 0..NW-1 in ascending order; for the last word, only the low OUT_W-32(NW-1) bits are written.
REQ-023 SHALL leave the LCG state unchanged in IDLE, VALID and DONE.
REQ-024 SHALL, in IDLE, go to FILL with k=0 and vec_cnt=0 when start is sampled high.
REQ-025 SHALL give a start-to-valid latency of NW+1 cycles: start high in cycle 0 means vec_valid high from cycle NW+1 (cycle 6 for OUT_W=139).
REQ-026 SHALL go from FILL to VALID after step k=NW-1.
REQ-027 SHALL hold vec_valid high in VALID and keep vec_data stable until vec_valid&vec_ready is sampled.
REQ-028 SHALL, on acceptance, increment vec_cnt modulo 2^CNT_W.
REQ-029 SHALL, on acceptance, go to DONE if num_vec!=0 and the incremented vec_cnt equals num_vec; otherwise it SHALL go to FILL with k=0.
REQ-030 SHALL assert done for the single cycle spent in DONE, then go to IDLE.
REQ-031 SHALL sample num_vec only when start is accepted; later changes are ignored until the next run.
REQ-032 SHALL, on stop high in FILL or VALID, go to IDLE on the next edge: vec_valid drops, no done pulse, vec_cnt and vec_data hold.
REQ-033 SHALL, if stop and vec_ready are high together in VALID, give stop priority: no count increment.
REQ-034 SHALL honour seed_load only in IDLE; seed_load while busy is ignored.
REQ-035 SHALL, for seed_load and start together in IDLE, load the seed first and make the first FILL step use seed_in.
REQ-036 SHALL ignore start while busy.
REQ-037 SHALL ignore start when stop is high in the same cycle.
REQ-038 SHALL, in a new run after an abort or a completed run, continue from the current LCG state; only seed_load or reset restarts the sequence.
REQ-039 SHALL drive busy = (state != IDLE).

Reset
REQ-040 SHALL, when rst_n is low, asynchronously force: FSM=IDLE, LCG state=SEED_DEF, vec_data=0, vec_cnt=0, vec_valid=0, done=0, busy=0.
REQ-041 SHALL, on rst_n low mid-run, discard the partial vector; after release it SHALL wait in IDLE for start.
REQ-042 SHALL release reset synchronously to clk, with outputs stable from the first edge after rst_n rises.

Verification
REQ-043 SHALL cover basic sequence: OUT_W=139, seed_load 0, start, num_vec=1, vec_ready=1 -> vec_data[31:0]=32'h00003039, [63:32]=32'hD3DC167E; done pulses one cycle after acceptance; vec_cnt=1.
REQ-044 SHALL cover backpressure: vec_ready low for 10 cycles in VALID -> vec_data and vec_valid stable throughout; one increment on the single handshake.
REQ-045 SHALL cover unbounded run: num_vec=0, vec_ready=1 for 100 vectors -> vec_cnt=100, no done; stop -> IDLE next cycle, no done.
REQ-046 SHALL cover reset mid-FILL: rst_n low at k=2 -> all outputs zero immediately; next run without seed_load -> first word equals the first LCG step from SEED_DEF.
REQ-047 SHALL cover simultaneous events: stop+vec_ready in VALID -> no increment; seed_load while busy -> ignored; start+stop in IDLE -> remains IDLE.
REQ-048 SHALL cover width corners: OUT_W=32 -> NW=1, valid 2 cycles after start; OUT_W=33 -> NW=2, bit 32 = LSB of step 2.
